sender_arbiter: RTL and testbench



---
 rtl/sender_arbiter_pkg.sv | 7 +
 rtl/rr_arbiter.sv | 28 ++
 rtl/sender_arbiter.sv | 113 +++++++++++
 tb/tb_sender_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sender_arbiter_pkg.sv
// Shared types and widths for the UART sender arbiter.
package sender_arbiter_pkg;
  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_BUSY, GAP} sarb_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester found searching upward
// from last+1 (mod NREQ). Outputs one-hot grant plus its index.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id
);
  logic [IDW-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest match is written last.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    idx    = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = IDW'((int'(last) + k) % NREQ);
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
        gnt_id   = idx;
      end
    end
  end
endmodule

// File: rtl/sender_arbiter.sv
// Round-robin share of the byte-wide UART sender: one 32-bit word per grant,
// 1-4 bytes MSB-first on valid/ready, one-cycle ack at capture.
module sender_arbiter
  import sender_arbiter_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*WORD_W-1:0]   word,
  input  logic [NREQ*2-1:0]        len,
  output logic [NREQ-1:0]          ack,
  input  logic                     sender_ready,
  output logic [BYTE_W-1:0]        output_data,
  output logic                     valid,
  output logic                     busy,
  output logic [IDW-1:0]           grant_id
);
  sarb_state_t        state_q, state_d;
  logic [WORD_W-1:0]  shreg_q, shreg_d;
  logic [1:0]         remain_q, remain_d;
  logic [IDW-1:0]     last_q, last_d;
  logic [IDW-1:0]     gid_q, gid_d;
  logic [NREQ-1:0]    ack_q, ack_d;
  logic [BYTE_W-1:0]  data_q, data_d;
  logic               valid_q, valid_d;

  logic [NREQ-1:0]    gnt;
  logic [IDW-1:0]     gnt_id;
  logic [WORD_W-1:0]  win_word;
  logic [1:0]         win_len;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .req    (req),
    .last   (last_q),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign win_word = word[gnt_id*WORD_W +: WORD_W];
  assign win_len  = len[gnt_id*2 +: 2];

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    remain_d = remain_q;
    last_d   = last_q;
    gid_d    = gid_q;
    ack_d    = '0;
    data_d   = data_q;
    valid_d  = valid_q;
    unique case (state_q)
      IDLE: if (|req) begin
        shreg_d  = win_word;
        remain_d = win_len;
        last_d   = gnt_id;
        gid_d    = gnt_id;
        ack_d    = gnt;
        data_d   = win_word[WORD_W-1 -: BYTE_W];
        valid_d  = 1'b1;
        state_d  = SEND;
      end
      SEND: if (sender_ready) begin
        valid_d = 1'b0;
        state_d = WAIT_BUSY;
      end
      // Ready dropping proves the sender latched the byte before we offer another.
      WAIT_BUSY: if (!sender_ready) begin
        if (remain_q != 2'd0) begin
          shreg_d  = shreg_q << BYTE_W;
          data_d   = shreg_q[WORD_W-BYTE_W-1 -: BYTE_W];
          remain_d = remain_q - 2'd1;
          valid_d  = 1'b1;
          state_d  = SEND;
        end else begin
          state_d = GAP;
        end
      end
      GAP: if (sender_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      remain_q <= '0;
      last_q   <= IDW'(NREQ-1);
      gid_q    <= '0;
      ack_q    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      remain_q <= remain_d;
      last_q   <= last_d;
      gid_q    <= gid_d;
      ack_q    <= ack_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
    end
  end

  assign ack         = ack_q;
  assign output_data = data_q;
  assign valid       = valid_q;
  assign busy        = (state_q != IDLE);
  assign grant_id    = gid_q;
endmodule

// File: tb/tb_sender_arbiter.sv
// Bench for sender_arbiter: queue-based requesters, a UART sender model with
// a busy period after each accepted byte, and an expected-byte scoreboard.
module tb_sender_arbiter;
  localparam int NREQ = 2;
  localparam int IDW  = 1;

  logic                CLK = 1'b0;
  logic                reset = 1'b1;
  logic [NREQ-1:0]     req = '0;
  logic [NREQ*32-1:0]  word = '0;
  logic [NREQ*2-1:0]   len = '0;
  logic [NREQ-1:0]     ack;
  logic                sender_ready = 1'b1;
  logic [7:0]          output_data;
  logic                valid;
  logic                busy;
  logic [IDW-1:0]      grant_id;

  sender_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .CLK(CLK), .reset(reset), .req(req), .word(word), .len(len), .ack(ack),
    .sender_ready(sender_ready), .output_data(output_data), .valid(valid),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 CLK = ~CLK;

  int tests = 0, fails = 0;
  logic [33:0] pend [NREQ][$];   // {len, word} waiting per requester
  logic [7:0]  exp_b[$], got_b[$];
  int          ack_ids[$];
  int          sbusy = 0, busy_len = 5;
  bit          stuck = 0, rand_busy = 0;
  int          m_last = NREQ-1;
  int          rr_err = 0, gid_err = 0, multi_ack = 0, dup_valid = 0;

  task automatic drive(input int i);
    word[32*i +: 32] = pend[i][0][31:0];
    len[2*i +: 2]    = pend[i][0][33:32];
    req[i]           = 1'b1;
  endtask

  task automatic post(input int i, input logic [31:0] w, input logic [1:0] l);
    pend[i].push_back({l, w});
    if (!req[i]) drive(i);
  endtask

  // One clock: sender model, requester model and observation recording.
  task automatic tick();
    logic acc;
    logic [NREQ-1:0] req_pre;
    int w;
    acc = valid && sender_ready;
    req_pre = req;
    if (acc) got_b.push_back(output_data);
    @(posedge CLK); #1;
    if (acc && valid) dup_valid++;
    if (acc) sbusy = rand_busy ? int'($urandom_range(1, 4)) : busy_len;
    else if (sbusy > 0) sbusy--;
    sender_ready = stuck || (sbusy == 0);
    if (ack != '0) begin
      if ($countones(ack) != 1) multi_ack++;
      w = -1;
      for (int k = 1; k <= NREQ; k++)
        if (w < 0 && req_pre[(m_last + k) % NREQ]) w = (m_last + k) % NREQ;
      for (int i = 0; i < NREQ; i++) if (ack[i]) begin
        ack_ids.push_back(i);
        if (i != w) rr_err++;
        if (int'(grant_id) != i) gid_err++;
        m_last = i;
        for (int b = 0; b <= int'(len[2*i +: 2]); b++)
          exp_b.push_back(word[32*i + 24 - 8*b +: 8]);
        void'(pend[i].pop_front());
        if (pend[i].size() > 0) drive(i); else req[i] = 1'b0;
      end
    end
  endtask

  function automatic bit all_idle();
    for (int i = 0; i < NREQ; i++) if (pend[i].size() != 0) return 1'b0;
    return !busy;
  endfunction

  task automatic drain(input int max, output bit timed_out);
    int n = 0;
    while (!all_idle() && n < max) begin tick(); n++; end
    timed_out = !all_idle();
  endtask

  task automatic clear();
    exp_b.delete(); got_b.delete(); ack_ids.delete();
    rr_err = 0; gid_err = 0; multi_ack = 0; dup_valid = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREQ; i++) pend[i].delete();
    req = '0; sbusy = 0; stuck = 0; sender_ready = 1'b1; m_last = NREQ-1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge CLK);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (ack !== 2'b00) begin fails++; $display("FAIL reset_ack got %b want 00", ack); end
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (output_data !== 8'h00) begin fails++; $display("FAIL reset_data got %h want 00", output_data); end
    tests++; if (grant_id !== 1'b0) begin fails++; $display("FAIL reset_gid got %0d want 0", grant_id); end
  endtask

  task automatic test_single();
    logic [7:0] e[4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    bit to; int bad = 0;
    clear(); rand_busy = 0; busy_len = 5;
    post(0, 32'hDEADBEEF, 2'd3);
    tick();
    tests++; if (ack !== 2'b01 || valid !== 1'b1 || output_data !== 8'hDE) begin
      fails++; $display("FAIL single_latency got ack=%b valid=%b data=%h want 01 1 de", ack, valid, output_data); end
    tick();
    tests++; if (ack !== 2'b00) begin fails++; $display("FAIL single_ack_width got %b want 00", ack); end
    drain(300, to);
    tests++; if (to) begin fails++; $display("FAIL single_timeout got busy=%b want done", busy); end
    tests++; if (got_b.size() != 4) begin fails++; $display("FAIL single_count got %0d want 4", got_b.size()); end
    else begin
      for (int k = 0; k < 4; k++) if (got_b[k] !== e[k]) bad++;
      tests++; if (bad != 0) begin fails++; $display("FAIL single_bytes got %h %h %h %h want de ad be ef", got_b[0], got_b[1], got_b[2], got_b[3]); end
    end
    tests++; if (ack_ids.size() != 1) begin fails++; $display("FAIL single_acks got %0d want 1", ack_ids.size()); end
    tests++; if (dup_valid != 0) begin fails++; $display("FAIL single_valid_fall got %0d want 0", dup_valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL single_busy_end got %b want 0", busy); end
  endtask

  task automatic test_short();
    bit to;
    clear(); busy_len = 3;
    post(1, 32'h41A5C3E7, 2'd0);
    drain(100, to);
    tests++; if (to || got_b.size() != 1) begin fails++; $display("FAIL short_count got %0d want 1", got_b.size()); end
    else begin
      tests++; if (got_b[0] !== 8'h41) begin fails++; $display("FAIL short_byte got %h want 41", got_b[0]); end
    end
    tests++; if (ack_ids.size() != 1 || ack_ids[0] != 1) begin fails++; $display("FAIL short_grant got n=%0d want requester 1", ack_ids.size()); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL short_idle got busy=%b want 0", busy); end
  endtask

  task automatic test_contention();
    bit to; int bad = 0;
    clear(); busy_len = 2;
    for (int n = 0; n < 3; n++) begin
      post(0, 32'hA0A1A2A3 + 32'(n), 2'(n + 1));
      post(1, 32'hB0B1B2B3 + 32'(n), 2'(n));
    end
    drain(2000, to);
    tests++; if (to) begin fails++; $display("FAIL contention_timeout got busy=%b want done", busy); end
    tests++; if (ack_ids.size() != 6) begin fails++; $display("FAIL contention_acks got %0d want 6", ack_ids.size()); end
    else begin
      for (int k = 0; k < 6; k++) if (ack_ids[k] != k % 2) bad++;
      tests++; if (bad != 0) begin fails++; $display("FAIL contention_order got %0d misordered want 0", bad); end
    end
    bad = 0;
    tests++; if (got_b.size() != exp_b.size() || exp_b.size() != 15) begin
      fails++; $display("FAIL contention_bytes got %0d want %0d (15)", got_b.size(), exp_b.size()); end
    else begin
      for (int k = 0; k < exp_b.size(); k++) if (got_b[k] !== exp_b[k]) bad++;
      tests++; if (bad != 0) begin fails++; $display("FAIL contention_data got %0d wrong bytes want 0", bad); end
    end
    tests++; if (gid_err != 0 || multi_ack != 0) begin fails++; $display("FAIL contention_gid got gid_err=%0d multi=%0d want 0 0", gid_err, multi_ack); end
  endtask

  task automatic test_late();
    logic [7:0] e[6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    bit to; int n = 0, bad = 0;
    clear(); busy_len = 3;
    post(0, 32'h11223344, 2'd3);
    while (got_b.size() < 1 && n < 100) begin tick(); n++; end
    post(1, 32'h55667788, 2'd1);
    drain(500, to);
    tests++; if (to || ack_ids.size() != 2) begin fails++; $display("FAIL late_acks got %0d want 2", ack_ids.size()); end
    else begin
      tests++; if (ack_ids[0] != 0 || ack_ids[1] != 1) begin fails++; $display("FAIL late_order got %0d,%0d want 0,1", ack_ids[0], ack_ids[1]); end
    end
    tests++; if (got_b.size() != 6) begin fails++; $display("FAIL late_count got %0d want 6", got_b.size()); end
    else begin
      for (int k = 0; k < 6; k++) if (got_b[k] !== e[k]) bad++;
      tests++; if (bad != 0) begin fails++; $display("FAIL late_bytes got %0d wrong want 0", bad); end
    end
  endtask

  task automatic test_reset_mid();
    bit to; int n = 0;
    clear(); busy_len = 2;
    post(0, 32'hCAFEF00D, 2'd3);
    while (got_b.size() < 2 && n < 100) begin tick(); n++; end
    tests++; if (got_b.size() != 2) begin fails++; $display("FAIL rstmid_pre got %0d want 2", got_b.size()); end
    #2 reset = 1'b1;
    #1;
    tests++; if (valid !== 1'b0 || busy !== 1'b0 || ack !== 2'b00 || output_data !== 8'h00 || grant_id !== 1'b0) begin
      fails++; $display("FAIL rstmid_async got v=%b b=%b a=%b d=%h g=%0d want all 0", valid, busy, ack, output_data, grant_id); end
    model_reset();
    repeat (3) tick();
    reset = 1'b0;
    repeat (3) tick();
    tests++; if (got_b.size() != 2) begin fails++; $display("FAIL rstmid_nomore got %0d want 2", got_b.size()); end
    post(1, 32'h5A000000, 2'd0);
    post(0, 32'hA5000000, 2'd0);
    tick();
    tests++; if (ack !== 2'b01) begin fails++; $display("FAIL rstmid_first got %b want 01", ack); end
    drain(200, to);
  endtask

  task automatic test_stuck();
    clear(); stuck = 1; sender_ready = 1'b1;
    post(0, 32'h99AABBCC, 2'd3);
    repeat (30) tick();
    tests++; if (got_b.size() != 1) begin fails++; $display("FAIL stuck_count got %0d want 1", got_b.size()); end
    tests++; if (busy !== 1'b1 || valid !== 1'b0) begin fails++; $display("FAIL stuck_state got busy=%b valid=%b want 1 0", busy, valid); end
    do_reset();
  endtask

  task automatic test_random();
    bit to; int bad = 0;
    clear(); rand_busy = 1;
    for (int n = 0; n < 24; n++) begin
      post(int'($urandom_range(0, NREQ-1)), $urandom, 2'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 6)) tick();
    end
    drain(5000, to);
    tests++; if (to) begin fails++; $display("FAIL random_timeout got busy=%b want done", busy); end
    tests++; if (ack_ids.size() != 24) begin fails++; $display("FAIL random_acks got %0d want 24", ack_ids.size()); end
    tests++; if (got_b.size() != exp_b.size()) begin fails++; $display("FAIL random_count got %0d want %0d", got_b.size(), exp_b.size()); end
    else begin
      for (int k = 0; k < exp_b.size(); k++) if (got_b[k] !== exp_b[k]) bad++;
      tests++; if (bad != 0) begin fails++; $display("FAIL random_bytes got %0d wrong want 0", bad); end
    end
    tests++; if (rr_err != 0) begin fails++; $display("FAIL random_rr got %0d wrong grants want 0", rr_err); end
    tests++; if (gid_err + multi_ack + dup_valid != 0) begin
      fails++; $display("FAIL random_proto got gid=%0d multi=%0d dup=%0d want 0", gid_err, multi_ack, dup_valid); end
    rand_busy = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_short();
    test_contention();
    test_late();
    test_reset_mid();
    test_stuck();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
